// File: rtl/fifo_read_checker.sv
// fifo_read_checker
//   Read-side consumer/checker for the fifo block. It pops a word on every
//   cycle it is allowed to while the fifo is non-empty. Each popped word is
//   compared against an expected counter sequence (SEED, SEED+INCR, ...).
//   It reports word count, error count, first-mismatch details and pass/fail.
//
// Ports
//   clk_i        single clock (fifo rclk shares this net)
//   reset_i      synchronous, active-high reset
//   start_i      1-cycle pulse, starts a run from IDLE or DONE
//   throttle_i   1: pop at most every other RUN cycle
//   rdata_i      fifo read data, valid whenever rempty_i=0
//   rempty_i     fifo empty flag
//   rinc_o       fifo pop strobe (combinational, gated by reset_i)
//   busy_o       high while a run is in progress
//   done_o       high once a run has finished; results hold here
//   pass_o       done with no mismatches and no timeout (combinational)
//   timeout_o    run was aborted because the fifo stayed empty too long
//   vectornum_o  words popped this run
//   errors_o     mismatches this run, saturating
//   err_idx_o    word index of the first mismatch
//   err_got_o    data seen at the first mismatch
//   err_exp_o    data expected at the first mismatch

module fifo_read_checker #(
  parameter int unsigned       WIDTH     = 32,
  parameter int unsigned       NUM_WORDS = 16,
  parameter logic [WIDTH-1:0]  SEED      = '0,
  parameter logic [WIDTH-1:0]  INCR      = WIDTH'(1),
  parameter int unsigned       TIMEOUT   = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             throttle_i,
  input  logic [WIDTH-1:0] rdata_i,
  input  logic             rempty_i,
  output logic             rinc_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             timeout_o,
  output logic [31:0]      vectornum_o,
  output logic [31:0]      errors_o,
  output logic [31:0]      err_idx_o,
  output logic [WIDTH-1:0] err_got_o,
  output logic [WIDTH-1:0] err_exp_o
);

  localparam int unsigned CNT_W    = 32;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q,     state_d;
  logic             phase_q,     phase_d;
  logic [CNT_W-1:0] idle_cnt_q,  idle_cnt_d;
  logic [CNT_W-1:0] vectornum_q, vectornum_d;
  logic [CNT_W-1:0] errors_q,    errors_d;
  logic [CNT_W-1:0] err_idx_q,   err_idx_d;
  logic [WIDTH-1:0] err_got_q,   err_got_d;
  logic [WIDTH-1:0] err_exp_q,   err_exp_d;
  logic [WIDTH-1:0] expected_q,  expected_d;
  logic             timeout_q,   timeout_d;

  logic             pop_c;
  logic             mismatch_c;

  // Pop strobe: only in RUN, never while reset is high, and on even phases
  // only when throttled.
  assign pop_c      = (state_q == ST_RUN) & ~rempty_i & ~reset_i &
                      (~throttle_i | ~phase_q);
  assign mismatch_c = (rdata_i != expected_q);

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      phase_q     <= 1'b0;
      idle_cnt_q  <= '0;
      vectornum_q <= '0;
      errors_q    <= '0;
      err_idx_q   <= '0;
      err_got_q   <= '0;
      err_exp_q   <= '0;
      expected_q  <= SEED;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      idle_cnt_q  <= idle_cnt_d;
      vectornum_q <= vectornum_d;
      errors_q    <= errors_d;
      err_idx_q   <= err_idx_d;
      err_got_q   <= err_got_d;
      err_exp_q   <= err_exp_d;
      expected_q  <= expected_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    idle_cnt_d  = idle_cnt_q;
    vectornum_d = vectornum_q;
    errors_d    = errors_q;
    err_idx_d   = err_idx_q;
    err_got_d   = err_got_q;
    err_exp_d   = err_exp_q;
    expected_d  = expected_q;
    timeout_d   = timeout_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // Run entry clears all results of the previous run.
        if (start_i) begin
          state_d     = ST_RUN;
          phase_d     = 1'b0;
          idle_cnt_d  = '0;
          vectornum_d = '0;
          errors_d    = '0;
          err_idx_d   = '0;
          err_got_d   = '0;
          err_exp_d   = '0;
          expected_d  = SEED;
          timeout_d   = 1'b0;
        end
      end

      ST_RUN: begin
        phase_d = ~phase_q;
        if (pop_c) begin
          // A pop on the timeout edge wins: counter clears, no abort.
          idle_cnt_d  = '0;
          vectornum_d = vectornum_q + CNT_W'(1);
          expected_d  = expected_q + INCR;
          if (mismatch_c) begin
            if (errors_q != '1) begin
              errors_d = errors_q + CNT_W'(1);
            end
            if (errors_q == '0) begin
              err_idx_d = vectornum_q;
              err_got_d = rdata_i;
              err_exp_d = expected_q;
            end
          end
          if (vectornum_q == LAST_IDX) begin
            state_d = ST_DONE;
          end
        end else if (idle_cnt_q == IDLE_MAX) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rinc_o      = pop_c;
  assign busy_o      = (state_q == ST_RUN);
  assign done_o      = (state_q == ST_DONE);
  assign pass_o      = (state_q == ST_DONE) & (errors_q == '0) & ~timeout_q;
  assign timeout_o   = timeout_q;
  assign vectornum_o = vectornum_q;
  assign errors_o    = errors_q;
  assign err_idx_o   = err_idx_q;
  assign err_got_o   = err_got_q;
  assign err_exp_o   = err_exp_q;

endmodule
